quad_encoder_decoder: RTL
=========================

Name: quad_encoder_decoder

Overview:
Quadrature encoder front-end for one drive wheel. It synchronises and glitch-filters the raw S_A/S_B sensor pair and decodes x4 quadrature steps. It maintains a signed position count and a per-window velocity sample, which feed the motor controller's Count output and the drive register block. There is one instance per wheel; the block is purely clk-domain after its input synchronisers.

Parameters:
FILTER_LEN, 4, consecutive cycles a synchronised input must differ from the filtered state before the filtered state accepts it (1..255)
CNT_W, 32, width of position and velocity outputs (two's complement)
VEL_WINDOW, 100000, velocity sampling window length in clk cycles (>=2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
s_a  in  1  raw encoder channel A, asynchronous
s_b  in  1  raw encoder channel B, asynchronous
dir_invert  in  1  1 = negate every decoded step
clear  in  1  synchronous position clear, single-cycle pulse
position  out  CNT_W  signed accumulated step count
velocity  out  CNT_W  signed steps counted in the last completed window
vel_valid  out  1  one-cycle pulse when velocity updates
err_count  out  16  illegal-transition count, saturating
err  out  1  one-cycle pulse per illegal transition

Behaviour:
- Reset values: position=0, velocity=0, vel_valid=0, err_count=0, err=0. Filter counters, window counter and accumulator are 0. Prime counter is 0.
- Sync: two flops per channel, giving sa_s and sb_s. The sync flops are not reset.
- Priming: for the first 3 cycles after rst deasserts, filt_ab <= {sa_s,sb_s} directly. During priming there is no decode, no step and no error. The window counter runs during priming.
- Filter (per channel, independent):
  - When sync != filt, cnt increments.
  - When cnt == FILTER_LEN-1 and sync != filt still holds, filt <= sync and cnt <= 0.
  - When sync == filt, cnt <= 0.
  - Net effect: a level stable for FILTER_LEN cycles at the sync output is accepted; any shorter pulse is ignored.
- Decode: compare prev_ab (registered filt_ab) with filt_ab each cycle.
  - Forward Gray sequence 00->01->11->10->00 gives step = +1.
  - Reverse sequence gives step = -1.
  - No change gives step = 0.
  - Both bits changing is illegal: step = 0, err pulses, and err_count increments, saturating at 16'hFFFF.
- dir_invert is applied to step combinationally; toggling it never generates a step.
- Position: position <= position + step, wrapping modulo 2^CNT_W.
  - If clear=1, position <= 0 and any same-cycle step is discarded.
  - clear does not affect velocity or err_count.
- Latency: a pin edge sampled at edge k, stable thereafter, appears in position at edge k+FILTER_LEN+3.
- Velocity: wcnt counts 0..VEL_WINDOW-1 and wraps.
  - Each cycle, acc <= acc + step.
  - On the cycle wcnt == VEL_WINDOW-1: velocity <= acc + step, acc <= 0, vel_valid=1 for that one cycle.
  - acc and velocity wrap modulo 2^CNT_W.
- Reset mid-operation clears all state as listed above and re-primes. No step is produced from a pre-reset filter state.

Test Plan:
1. Reset, then s_a/s_b held at 11 -> after priming, position=0, err=0, err_count=0 (no spurious step).
2. FILTER_LEN=4; drive forward sequence 00->01->11->10->00 for 10 full cycles, each level held 8 clk -> position=40. Each step appears FILTER_LEN+3=7 clk after its pin edge.
3. Same stimulus with dir_invert=1 -> position=-40 (32'hFFFFFFD8). Then 3-clk-wide glitches on s_a -> position unchanged.
4. Filtered 00 jumps directly to 11 -> err pulses exactly one cycle, err_count=1, position unchanged. Then 65540 illegal jumps -> err_count=16'hFFFF.
5. Position at 32'h7FFFFFFF plus one forward step -> 32'h80000000. clear asserted coincident with a step -> position=0.
6. VEL_WINDOW=100: 25 forward steps inside one window -> on the window's last cycle, vel_valid=1 for 1 clk and velocity=25. Next window with no steps -> velocity=0.

Source files
------------

// File: rtl/quad_encoder_decoder.sv
// ---------------------------------------------------------------------------
// quad_encoder_decoder
//
// Quadrature encoder front-end for one drive wheel. The raw S_A/S_B pair is
// brought into the clk domain by a two-flop synchroniser per channel and then
// glitch-filtered: a channel's filtered level only moves after the
// synchronised input has disagreed with it for FILTER_LEN consecutive cycles.
// The filtered pair is decoded as x4 quadrature (forward Gray order
// 00->01->11->10->00). The result drives a wrapping signed position counter
// and a per-window velocity sample. Both bits changing at once is illegal.
// It flags err and bumps a saturating error counter.
//
// Ports
//   clk        : clock
//   rst        : synchronous, active-high reset
//   s_a, s_b   : raw encoder channels, asynchronous to clk
//   dir_invert : 1 = negate every decoded step (applied combinationally)
//   clear      : single-cycle synchronous position clear (wins over a step)
//   position   : signed accumulated step count, wraps modulo 2^CNT_W
//   velocity   : signed step count of the last completed window
//   vel_valid  : one-cycle pulse on the cycle velocity shows a new sample
//   err_count  : illegal-transition count, saturates at 16'hFFFF
//   err        : one-cycle pulse per illegal transition
//
// Pin-to-position latency is FILTER_LEN+3 clocks: two synchroniser stages,
// FILTER_LEN-1 counting cycles plus the accepting edge, one registered
// decode stage, then the position register itself.
// ---------------------------------------------------------------------------
module quad_encoder_decoder #(
  parameter int FILTER_LEN = 4,       // 1..255
  parameter int CNT_W      = 32,
  parameter int VEL_WINDOW = 100000   // >= 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_a,
  input  logic                    s_b,
  input  logic                    dir_invert,
  input  logic                    clear,
  output logic signed [CNT_W-1:0] position,
  output logic signed [CNT_W-1:0] velocity,
  output logic                    vel_valid,
  output logic [15:0]             err_count,
  output logic                    err
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
  localparam int WCW = $clog2(VEL_WINDOW);
  localparam logic [WCW-1:0] WIN_LAST = WCW'(VEL_WINDOW - 1);
  localparam logic [1:0] PRIME_CYCLES = 2'd3;
  localparam logic signed [CNT_W-1:0] STEP_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,
    STEP_FWD  = 2'b01,
    STEP_REV  = 2'b10
  } step_e;

  // Bit 1 carries channel A, bit 0 channel B throughout.
  logic [1:0]     sync_meta;
  logic [1:0]     sync_ab;
  logic [1:0]     filt_ab;
  logic [1:0]     prev_ab;
  logic [FCW-1:0] fcnt [2];
  logic [1:0]     prime_cnt;
  logic           primed;

  step_e                   dec_step;
  logic                    dec_err;
  step_e                   step_q;
  logic signed [CNT_W-1:0] step_val;

  logic [WCW-1:0]          wcnt;
  logic signed [CNT_W-1:0] acc;

  // NOTE: synchroniser flops carry no reset; they only ever hold a sampled
  // pin level and resetting them would put rst on a metastability path.
  always_ff @(posedge clk) begin
    sync_meta <= {s_a, s_b};
    sync_ab   <= sync_meta;
  end

  assign primed = (prime_cnt == PRIME_CYCLES);

  // Filter, priming and the registered decode stage. During priming the
  // filtered and previous pairs are both loaded straight from the
  // synchroniser, so the first real decode compares equal values and a
  // pre-reset filter state can never turn into a step.
  // NOTE: every state register here uses non-blocking assignment so all
  // flops sample the values from before the edge, whatever the block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      prime_cnt <= '0;
      filt_ab   <= '0;
      prev_ab   <= '0;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
      step_q    <= STEP_NONE;
      err       <= 1'b0;
      err_count <= '0;
    end else if (!primed) begin
      prime_cnt <= prime_cnt + 2'd1;
      filt_ab   <= sync_ab;
      prev_ab   <= sync_ab;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
      step_q    <= STEP_NONE;
      err       <= 1'b0;
    end else begin
      // Each channel runs its own counter; a level is accepted on the
      // FILTER_LEN-th consecutive cycle of disagreement.
      for (int i = 0; i < 2; i++) begin
        if (sync_ab[i] != filt_ab[i]) begin
          if (fcnt[i] == FILT_LAST) begin
            filt_ab[i] <= sync_ab[i];
            fcnt[i]    <= '0;
          end else begin
            fcnt[i] <= fcnt[i] + 1'b1;
          end
        end else begin
          fcnt[i] <= '0;
        end
      end
      prev_ab <= filt_ab;
      step_q  <= dec_step;
      err     <= dec_err;
      if (dec_err && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
    end
  end

  // Quadrature decode of the previous vs current filtered pair.
  // NOTE: outputs get defaults before the case so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    dec_step = STEP_NONE;
    dec_err  = 1'b0;
    case ({prev_ab, filt_ab})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: dec_step = STEP_FWD;
      4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: dec_step = STEP_REV;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: dec_err  = 1'b1;
      default: ;
    endcase
  end

  // Direction inversion acts on the registered step only, so flipping
  // dir_invert while idle cannot create a step.
  always_comb begin
    step_val = '0;
    case (step_q)
      STEP_FWD: step_val = dir_invert ? -STEP_ONE : STEP_ONE;
      STEP_REV: step_val = dir_invert ? STEP_ONE : -STEP_ONE;
      default:  step_val = '0;
    endcase
  end

  // Position and velocity. clear only touches position; the window counter
  // and accumulator keep running regardless of clear or priming.
  always_ff @(posedge clk) begin
    if (rst) begin
      position  <= '0;
      velocity  <= '0;
      vel_valid <= 1'b0;
      wcnt      <= '0;
      acc       <= '0;
    end else begin
      position <= clear ? '0 : position + step_val;
      if (wcnt == WIN_LAST) begin
        wcnt      <= '0;
        velocity  <= acc + step_val;
        acc       <= '0;
        vel_valid <= 1'b1;
      end else begin
        wcnt      <= wcnt + 1'b1;
        acc       <= acc + step_val;
        vel_valid <= 1'b0;
      end
    end
  end

endmodule
